// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Owner encoding is also the rr_pick winner encoding.
package dmem_port_arbiter_pkg;

  typedef logic owner_t;

  localparam owner_t     OWNER_CORE = 1'b0;
  localparam owner_t     OWNER_DBG  = 1'b1;
  localparam logic [3:0] WE_NONE    = 4'b0;

  // Tracks the single read in flight so the next-cycle BRAM data goes to its owner.
  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;

  localparam rd_tag_t RD_TAG_IDLE = '{valid: 1'b0, owner: OWNER_CORE};

  function automatic logic is_read(input logic [3:0] we);
    return we == WE_NONE;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Requester and BRAM port-B signal bundle for dmem_port_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface dmem_port_arbiter_if;

  logic        c_req;
  logic [3:0]  c_we;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic        c_gnt;
  logic        c_stall;
  logic        c_rvalid;
  logic [31:0] c_rdata;

  logic        d_req;
  logic        d_lock;
  logic [3:0]  d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic [3:0]  m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_dout;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_gnt, c_stall, c_rvalid, c_rdata,
    input  d_req, d_lock, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_we, m_addr, m_wdata,
    input  m_dout
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_gnt, c_stall, c_rvalid, c_rdata,
    output d_req, d_lock, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_we, m_addr, m_wdata,
    output m_dout
  );

endinterface

// File: rtl/dmem_port_arbiter_rr_pick.sv
// Combinational two-way pick: lock, single requester, forced dbg, then preference pointer.
// req[0] is the core side, req[1] the dbg side.
module dmem_port_arbiter_rr_pick
  import dmem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       force_dbg,
  input  logic       lock,
  output logic       gnt_vld,
  output owner_t     winner,
  output logic       next_ptr
);

  always_comb begin
    gnt_vld  = |req;
    winner   = OWNER_CORE;
    next_ptr = ptr;
    if (lock && req[1]) begin
      winner = OWNER_DBG;
    end else if (req == 2'b10) begin
      winner = OWNER_DBG;
    end else if (req == 2'b11) begin
      winner = (force_dbg || ptr) ? OWNER_DBG : OWNER_CORE;
    end
    // After contention the loser becomes preferred; ptr and owner share encoding.
    if (req == 2'b11) next_ptr = ~winner;
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares BRAM port B between the LSU and the debug loader, one access per cycle,
// steering the 1-cycle-latency read data back to whichever side issued the read.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter bit          RR_EN    = 1'b1,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  dmem_port_arbiter_if.slave bus
);

  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

  logic       ptr_q, ptr_d;
  logic       locked_q, locked_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  rd_tag_t    rd_tag_q, rd_tag_d;

  logic       pick_vld;
  owner_t     pick_owner;
  logic       pick_next_ptr;
  logic       c_gnt, d_gnt;
  logic [3:0] m_we_sel;

  dmem_port_arbiter_rr_pick u_pick (
    .req       ({bus.d_req, bus.c_req}),
    .ptr       (ptr_q),
    .force_dbg (wait_cnt_q == WAIT_LIM),
    .lock      (locked_q),
    .gnt_vld   (pick_vld),
    .winner    (pick_owner),
    .next_ptr  (pick_next_ptr)
  );

  // Grants and port mux; reset suppresses every grant so no write can slip through.
  always_comb begin
    c_gnt    = ~rst & pick_vld & (pick_owner == OWNER_CORE);
    d_gnt    = ~rst & pick_vld & (pick_owner == OWNER_DBG);
    m_we_sel = WE_NONE;
    if (c_gnt)      m_we_sel = bus.c_we;
    else if (d_gnt) m_we_sel = bus.d_we;
  end

  always_comb begin
    bus.c_gnt   = c_gnt;
    bus.d_gnt   = d_gnt;
    bus.c_stall = bus.c_req & ~c_gnt;
    bus.m_we    = m_we_sel;
    bus.m_addr  = d_gnt ? bus.d_addr  : bus.c_addr;
    bus.m_wdata = d_gnt ? bus.d_wdata : bus.c_wdata;
  end

  always_comb begin
    ptr_d    = RR_EN ? pick_next_ptr : 1'b0;
    locked_d = d_gnt & bus.d_lock;

    wait_cnt_d = 8'd0;
    if (bus.d_req && !d_gnt)
      wait_cnt_d = (wait_cnt_q == WAIT_LIM) ? wait_cnt_q : wait_cnt_q + 8'd1;

    rd_tag_d = RD_TAG_IDLE;
    if ((c_gnt || d_gnt) && is_read(m_we_sel))
      rd_tag_d = '{valid: 1'b1, owner: d_gnt ? OWNER_DBG : OWNER_CORE};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= 1'b0;
      locked_q   <= 1'b0;
      wait_cnt_q <= 8'd0;
      rd_tag_q   <= RD_TAG_IDLE;
    end else begin
      ptr_q      <= ptr_d;
      locked_q   <= locked_d;
      wait_cnt_q <= wait_cnt_d;
      rd_tag_q   <= rd_tag_d;
    end
  end

  // Read return: a read in flight when reset is asserted is silently dropped.
  always_comb begin
    bus.c_rvalid = ~rst & rd_tag_q.valid & (rd_tag_q.owner == OWNER_CORE);
    bus.d_rvalid = ~rst & rd_tag_q.valid & (rd_tag_q.owner == OWNER_DBG);
    bus.c_rdata  = bus.c_rvalid ? bus.m_dout : 32'd0;
    bus.d_rdata  = bus.d_rvalid ? bus.m_dout : 32'd0;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Drives a round-robin (MAX_WAIT 8) and a fixed-priority (MAX_WAIT 3) arbiter with the same
// stimulus; each is compared against a rule-level model and a shadow copy of its BRAM.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst, init;
  logic        c_req, d_req, d_lock;
  logic [3:0]  c_we, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter_if bus0 ();
  dmem_port_arbiter_if bus1 ();

  dmem_port_arbiter #(.RR_EN(1'b1), .MAX_WAIT(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  dmem_port_arbiter #(.RR_EN(1'b0), .MAX_WAIT(3)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  assign bus0.c_req = c_req;   assign bus1.c_req = c_req;
  assign bus0.c_we = c_we;     assign bus1.c_we = c_we;
  assign bus0.c_addr = c_addr; assign bus1.c_addr = c_addr;
  assign bus0.c_wdata = c_wdata; assign bus1.c_wdata = c_wdata;
  assign bus0.d_req = d_req;   assign bus1.d_req = d_req;
  assign bus0.d_lock = d_lock; assign bus1.d_lock = d_lock;
  assign bus0.d_we = d_we;     assign bus1.d_we = d_we;
  assign bus0.d_addr = d_addr; assign bus1.d_addr = d_addr;
  assign bus0.d_wdata = d_wdata; assign bus1.d_wdata = d_wdata;

  function automatic logic [31:0] seed_word(input int i);
    return {i[7:0], ~i[7:0], i[7:0] ^ 8'h5A, 8'hC3};
  endfunction

  // BRAM port-B models: byte-enabled write, registered read (read-first).
  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];

  always @(posedge clk) begin
    if (init) for (int i = 0; i < 256; i++) mem0[i] <= seed_word(i);
    else for (int b = 0; b < 4; b++)
      if (bus0.m_we[b]) mem0[bus0.m_addr[9:2]][b*8 +: 8] <= bus0.m_wdata[b*8 +: 8];
    bus0.m_dout <= mem0[bus0.m_addr[9:2]];
  end

  always @(posedge clk) begin
    if (init) for (int j = 0; j < 256; j++) mem1[j] <= seed_word(j);
    else for (int e = 0; e < 4; e++)
      if (bus1.m_we[e]) mem1[bus1.m_addr[9:2]][e*8 +: 8] <= bus1.m_wdata[e*8 +: 8];
    bus1.m_dout <= mem1[bus1.m_addr[9:2]];
  end

  logic [1:0]  o_cg, o_dg, o_cs, o_crv, o_drv;
  logic [31:0] o_crd [2];
  logic [31:0] o_drd [2];
  logic [31:0] o_ma  [2];
  logic [31:0] o_mwd [2];
  logic [3:0]  o_we  [2];

  assign o_cg  = {bus1.c_gnt,    bus0.c_gnt};
  assign o_dg  = {bus1.d_gnt,    bus0.d_gnt};
  assign o_cs  = {bus1.c_stall,  bus0.c_stall};
  assign o_crv = {bus1.c_rvalid, bus0.c_rvalid};
  assign o_drv = {bus1.d_rvalid, bus0.d_rvalid};
  assign o_crd[0] = bus0.c_rdata;  assign o_crd[1] = bus1.c_rdata;
  assign o_drd[0] = bus0.d_rdata;  assign o_drd[1] = bus1.d_rdata;
  assign o_ma[0]  = bus0.m_addr;   assign o_ma[1]  = bus1.m_addr;
  assign o_mwd[0] = bus0.m_wdata;  assign o_mwd[1] = bus1.m_wdata;
  assign o_we[0]  = bus0.m_we;     assign o_we[1]  = bus1.m_we;

  // Reference model state, one set per DUT.
  bit          RRV [2] = '{1'b1, 1'b0};
  int          MWV [2] = '{8, 3};
  bit          mptr [2];
  bit          mlock [2];
  int          mwait [2];
  bit          mrv [2];
  bit          mown [2];
  logic [31:0] mrd [2];
  bit          egc [2];
  bit          egd [2];
  logic [31:0] shadow [2][256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic [3:0] cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dl, input logic [3:0] dw, input logic [31:0] da,
                       input logic [31:0] dd);
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    d_req = dr; d_lock = dl; d_we = dw; d_addr = da; d_wdata = dd;
  endtask

  // Mid-cycle: predict this cycle's grants from the rules and compare every output.
  task automatic mid();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      bit gc, gd, erv_c, erv_d;
      logic [3:0] ewe;
      gc = 1'b0; gd = 1'b0;
      if (!rst) begin
        if (mlock[k] && d_req) gd = 1'b1;
        else if (c_req && d_req) begin
          if (mwait[k] == MWV[k] || mptr[k]) gd = 1'b1; else gc = 1'b1;
        end
        else if (c_req) gc = 1'b1;
        else if (d_req) gd = 1'b1;
      end
      egc[k] = gc; egd[k] = gd;
      ewe = gc ? c_we : (gd ? d_we : 4'h0);
      erv_c = !rst && mrv[k] && !mown[k];
      erv_d = !rst && mrv[k] && mown[k];
      chk($sformatf("c_gnt%0d", k),   32'(o_cg[k]), 32'(gc));
      chk($sformatf("d_gnt%0d", k),   32'(o_dg[k]), 32'(gd));
      chk($sformatf("c_stall%0d", k), 32'(o_cs[k]), 32'(c_req && !gc));
      chk($sformatf("m_we%0d", k),    32'(o_we[k]), 32'(ewe));
      chk($sformatf("m_addr%0d", k),  o_ma[k], gd ? d_addr : c_addr);
      if (gc || gd) chk($sformatf("m_wdata%0d", k), o_mwd[k], gd ? d_wdata : c_wdata);
      chk($sformatf("c_rvalid%0d", k), 32'(o_crv[k]), 32'(erv_c));
      chk($sformatf("d_rvalid%0d", k), 32'(o_drv[k]), 32'(erv_d));
      chk($sformatf("c_rdata%0d", k),  o_crd[k], erv_c ? mrd[k] : 32'd0);
      chk($sformatf("d_rdata%0d", k),  o_drd[k], erv_d ? mrd[k] : 32'd0);
    end
  endtask

  // Clock edge: advance model state with the inputs that were present at the edge.
  task automatic fin();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      logic [7:0]  idx;
      logic [3:0]  we;
      logic [31:0] wd;
      if (rst) begin
        mptr[k] = 0; mlock[k] = 0; mwait[k] = 0; mrv[k] = 0;
      end else begin
        idx = egd[k] ? d_addr[9:2] : c_addr[9:2];
        we  = egd[k] ? d_we : c_we;
        wd  = egd[k] ? d_wdata : c_wdata;
        mrv[k] = 0;
        if (egc[k] || egd[k]) begin
          if (we == 4'h0) begin
            mrv[k] = 1; mown[k] = egd[k]; mrd[k] = shadow[k][idx];
          end else begin
            for (int b = 0; b < 4; b++) if (we[b]) shadow[k][idx][b*8 +: 8] = wd[b*8 +: 8];
          end
        end
        if (RRV[k] && c_req && d_req) mptr[k] = egc[k];
        mlock[k] = egd[k] && d_lock;
        if (d_req && !egd[k]) mwait[k] = (mwait[k] >= MWV[k]) ? MWV[k] : mwait[k] + 1;
        else mwait[k] = 0;
      end
    end
  endtask

  task automatic cyc();
    mid();
    fin();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    init = 1'b1;
    rst  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      mptr[k] = 0; mlock[k] = 0; mwait[k] = 0; mrv[k] = 0; mown[k] = 0; mrd[k] = 32'd0;
      for (int i = 0; i < 256; i++) shadow[k][i] = seed_word(i);
    end
    drive(0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    cyc();
    init = 1'b0;
    do_reset();

    // Core alone: same-cycle grant, data next cycle.
    drive(1, 4'hF, 32'h10, 32'hDEADBEEF, 0, 0, 4'h0, 32'h0, 32'h0);
    cyc();
    drive(1, 4'h0, 32'h10, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    mid();
    chk("t1_c_gnt", 32'(o_cg[0]), 32'd1);
    chk("t1_c_stall", 32'(o_cs[0]), 32'd0);
    fin();
    drive(0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    mid();
    chk("t1_c_rvalid", 32'(o_crv[0]), 32'd1);
    chk("t1_c_rdata", o_crd[0], 32'hDEADBEEF);
    chk("t1_d_rvalid", 32'(o_drv[0]), 32'd0);
    fin();

    // Contention from reset: dut0 alternates, dut1 starves dbg for 3 cycles.
    do_reset();
    drive(1, 4'h0, 32'h10, 32'h0, 1, 0, 4'h0, 32'h20, 32'h0);
    for (int i = 0; i < 6; i++) begin
      mid();
      chk("t2_c_gnt", 32'(o_cg[0]), 32'(i % 2 == 0));
      chk("t2_c_stall", 32'(o_cs[0]), 32'(i % 2 == 1));
      if (i > 0) chk("t2_c_rvalid", 32'(o_crv[0]), 32'((i - 1) % 2 == 0));
      if (i > 0) chk("t2_d_rvalid", 32'(o_drv[0]), 32'((i - 1) % 2 == 1));
      chk("t3_d_gnt", 32'(o_dg[1]), 32'(i == 3));
      fin();
    end

    // Locked dbg write burst against a requesting core.
    do_reset();
    drive(1, 4'h0, 32'h40, 32'h0, 1, 0, 4'h0, 32'h200, 32'h0);
    cyc();
    for (int j = 0; j < 4; j++) begin
      drive(1, 4'h0, 32'h40, 32'h0, 1, j < 3, 4'hF, 32'h100 + 32'(4 * j), 32'(j + 1));
      mid();
      chk("t4_d_gnt", 32'(o_dg[0]), 32'd1);
      chk("t4_c_stall", 32'(o_cs[0]), 32'd1);
      fin();
    end
    for (int j = 0; j < 5; j++) begin
      if (j < 4) drive(1, 4'h0, 32'h100 + 32'(4 * j), 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
      else       drive(0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
      mid();
      if (j == 0) chk("t4_c_gnt_after", 32'(o_cg[0]), 32'd1);
      if (j > 0)  chk("t4_readback", o_crd[0], 32'(j));
      fin();
    end

    // Reset with a locked dbg read in flight.
    do_reset();
    drive(0, 4'h0, 32'h0, 32'h0, 1, 1, 4'h0, 32'h100, 32'h0);
    mid();
    chk("t5_d_gnt", 32'(o_dg[0]), 32'd1);
    fin();
    rst = 1'b1;
    drive(1, 4'h0, 32'h10, 32'h0, 1, 1, 4'h0, 32'h100, 32'h0);
    mid();
    chk("t5_d_rvalid_rst", 32'(o_drv[0]), 32'd0);
    chk("t5_gnts_rst", 32'({o_cg, o_dg}), 32'd0);
    fin();
    rst = 1'b0;
    mid();
    chk("t5_c_gnt_after", 32'(o_cg[0]), 32'd1);
    fin();

    // Byte-lane write merge.
    do_reset();
    drive(1, 4'hF, 32'h20, 32'h11223344, 0, 0, 4'h0, 32'h0, 32'h0);
    cyc();
    drive(1, 4'b0010, 32'h20, 32'h0000AB00, 0, 0, 4'h0, 32'h0, 32'h0);
    cyc();
    drive(1, 4'h0, 32'h20, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    cyc();
    drive(0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    mid();
    chk("t6_byte_merge", o_crd[0], 32'h1122AB44);
    fin();

    // Randomized traffic, including occasional reset.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 60) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) ? 4'($urandom) : 4'h0, $urandom, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 1) ? 4'($urandom) : 4'h0, $urandom, $urandom);
      cyc();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
